// File: rtl/pool_pkg.sv
// Shared widths and signed helpers for the ReLU/max-pool layers.
package pool_pkg;

    localparam int unsigned SMAX_W     = 32;
    localparam int unsigned FIFO_DEPTH = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// Two-entry in-order output buffer; head entry is always r_mem0.
module pool_out_fifo
    import pool_pkg::*;
#(
    parameter int unsigned T = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [T-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [T-1:0] dout,
    output logic         empty
);

    localparam int unsigned C_W = cnt_w(FIFO_DEPTH + 1);

    logic [C_W-1:0] r_cnt;
    logic [T-1:0]   r_mem0;
    logic [T-1:0]   r_mem1;
    logic           w_push;
    logic           w_pop;

    assign full   = (r_cnt == C_W'(FIFO_DEPTH));
    assign empty  = (r_cnt == '0);
    assign dout   = r_mem0;
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_mem0 <= '0;
            r_mem1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == '0) r_mem0 <= din;
                    else             r_mem1 <= din;
                    r_cnt <= r_cnt + C_W'(1);
                end
                2'b01: begin
                    r_mem0 <= r_mem1;
                    r_cnt  <= r_cnt - C_W'(1);
                end
                2'b11: begin
                    // Occupancy unchanged; new entry lands behind whatever remains.
                    if (r_cnt == C_W'(1)) begin
                        r_mem0 <= din;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/relu_pool_32_2_16.sv
// ReLU followed by non-overlapping width-K max-pool over N-element vectors,
// with valid/ready streaming on both sides and a 2-entry output buffer.
module relu_pool_32_2_16
    import pool_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned K = 2,
    parameter int unsigned T = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [T-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready
);

    localparam int unsigned W_W = cnt_w(K);
    localparam int unsigned E_W = cnt_w(N);

    if ((K < 2) || ((N % K) != 0)) begin : g_bad_window
        $error("relu_pool: need K >= 2 and N %% K == 0 (N=%0d K=%0d)", N, K);
    end
    if (T > SMAX_W) begin : g_bad_width
        $error("relu_pool: T=%0d exceeds comparator width %0d", T, SMAX_W);
    end

    logic [W_W-1:0]          r_w;
    logic [E_W-1:0]          r_e;
    logic signed [T-1:0]     r_m;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic signed [SMAX_W-1:0] w_x_ext;
    logic signed [SMAX_W-1:0] w_base_ext;
    logic signed [SMAX_W-1:0] w_max_ext;
    logic signed [T-1:0]     w_m_next;
    logic [T-1:0]            w_dout;

    assign w_last   = (r_w == W_W'(K - 1));
    assign x_ready  = !w_last || !w_full;
    assign w_accept = x_valid && x_ready;
    assign y_valid  = !w_empty;
    assign y_data   = w_dout;
    assign w_pop    = y_valid && y_ready;

    // Starting a window from zero folds the ReLU into the running max.
    assign w_x_ext    = SMAX_W'(x_data);
    assign w_base_ext = (r_w == '0) ? '0 : SMAX_W'(r_m);
    assign w_max_ext  = smax(w_base_ext, w_x_ext);
    assign w_m_next   = T'(w_max_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w <= '0;
            r_e <= '0;
            r_m <= '0;
        end else if (w_accept) begin
            r_w <= w_last ? '0 : r_w + W_W'(1);
            r_e <= (r_e == E_W'(N - 1)) ? '0 : r_e + E_W'(1);
            r_m <= w_m_next;
        end
    end

    pool_out_fifo #(
        .T(T)
    ) u_out_fifo (
        .clk  (clk),
        .reset(reset),
        .push (w_accept && w_last),
        .din  (w_m_next),
        .full (w_full),
        .pop  (w_pop),
        .dout (w_dout),
        .empty(w_empty)
    );

endmodule
